// File: rtl/hazard_ctrl_if.sv
// Hazard-unit signal bundle between the pipeline datapath and hazard_ctrl.
// master = pipeline side (drives stage info), slave = hazard_ctrl (drives controls).
interface hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] Rs1D, Rs2D;
  logic [REG_W-1:0] Rs1E, Rs2E, RdE;
  logic [REG_W-1:0] RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  logic             MemAccessM;
  logic             mem_ready;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM, StallW;
  logic             FlushD, FlushE;
  logic             mem_req;
  logic             mem_timeout;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemAccessM, mem_ready,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
           FlushD, FlushE, mem_req, mem_timeout
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemAccessM, mem_ready,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
           FlushD, FlushE, mem_req, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard unit: forwarding, load-use interlock, branch flush, mem wait FSM.
// Controls are combinational in the hazard cycle; only FSM state, wait count and timeout flag are registered.
module hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT)
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [0:0]       IDLE    = 1'b0;
  localparam logic [0:0]       WAIT    = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [REG_W-1:0] X0      = '0;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [1:0] fwd_a, fwd_b;
  logic       lw_stall, mem_stall, mem_req, timeout_hit;

  // Memory stage wins over writeback: it holds the younger value.
  always_comb begin
    fwd_a = 2'b00;
    if (hz.RegWriteM && hz.RdM != X0 && hz.RdM == hz.Rs1E)      fwd_a = 2'b10;
    else if (hz.RegWriteW && hz.RdW != X0 && hz.RdW == hz.Rs1E) fwd_a = 2'b01;
    fwd_b = 2'b00;
    if (hz.RegWriteM && hz.RdM != X0 && hz.RdM == hz.Rs2E)      fwd_b = 2'b10;
    else if (hz.RegWriteW && hz.RdW != X0 && hz.RdW == hz.Rs2E) fwd_b = 2'b01;
  end

  assign lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != X0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    mem_req     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        mem_req = hz.MemAccessM;
        if (hz.MemAccessM && !hz.mem_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        if (hz.mem_ready) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          // Release without data; the IDLE cycle plus MEM_TIMEOUT-1 WAIT cycles were stalled.
          timeout_hit = 1'b1;
          timeout_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_stall = mem_req && !hz.mem_ready && !timeout_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // While in reset the pipeline registers are flushed and nothing is held.
  assign hz.ForwardAE   = reset ? fwd_a : 2'b00;
  assign hz.ForwardBE   = reset ? fwd_b : 2'b00;
  assign hz.StallF      = reset && (lw_stall || mem_stall);
  assign hz.StallD      = reset && (lw_stall || mem_stall);
  assign hz.StallE      = reset && mem_stall;
  assign hz.StallM      = reset && mem_stall;
  assign hz.StallW      = reset && mem_stall;
  assign hz.FlushD      = !reset || (hz.PCSrcE && !mem_stall);
  assign hz.FlushE      = !reset || ((lw_stall || hz.PCSrcE) && !mem_stall);
  assign hz.mem_req     = reset && mem_req;
  assign hz.mem_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: combinational vector table plus cycle sequences for
// wait states, timeout, branch-under-stall and asynchronous reset mid-access.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww;
    logic [1:0] rsrc;
    logic       pcsrc, macc, rdy;
  } in_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic sf, sd, se, sm, sw, fd, fe, req, tmo;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk;
  logic reset;
  int   ntests;
  int   nfail;
  out_t sb[$];
  vec_t vecs[12];

  hazard_ctrl_if #(.REG_W(5)) hz ();

  hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mkin(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                               input logic rwm, rww, input logic [1:0] rsrc,
                               input logic pcsrc, macc, rdy);
    in_t v;
    v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rwm = rwm; v.rww = rww;
    v.rsrc = rsrc; v.pcsrc = pcsrc; v.macc = macc; v.rdy = rdy;
    return v;
  endfunction

  function automatic out_t mk(input logic [1:0] fa, fb, input logic sfd, sbk, fd, fe, req, tmo);
    out_t o;
    o.fa = fa; o.fb = fb; o.sf = sfd; o.sd = sfd;
    o.se = sbk; o.sm = sbk; o.sw = sbk;
    o.fd = fd; o.fe = fe; o.req = req; o.tmo = tmo;
    return o;
  endfunction

  function automatic out_t get_out();
    out_t o;
    o.fa = hz.ForwardAE; o.fb = hz.ForwardBE;
    o.sf = hz.StallF; o.sd = hz.StallD; o.se = hz.StallE; o.sm = hz.StallM; o.sw = hz.StallW;
    o.fd = hz.FlushD; o.fe = hz.FlushE; o.req = hz.mem_req; o.tmo = hz.mem_timeout;
    return o;
  endfunction

  task automatic drive(input in_t v);
    hz.Rs1D = v.rs1d; hz.Rs2D = v.rs2d; hz.Rs1E = v.rs1e; hz.Rs2E = v.rs2e;
    hz.RdE = v.rde; hz.RdM = v.rdm; hz.RdW = v.rdw;
    hz.RegWriteM = v.rwm; hz.RegWriteW = v.rww; hz.ResultSrcE = v.rsrc;
    hz.PCSrcE = v.pcsrc; hz.MemAccessM = v.macc; hz.mem_ready = v.rdy;
  endtask

  task automatic check(input string name, input out_t mask);
    out_t e, a;
    ntests++;
    a = get_out();
    if (sb.size() == 0) begin
      nfail++;
      $display("FAIL %s: scoreboard empty, got %b", name, a);
    end else begin
      e = sb.pop_front();
      if ((a & mask) !== (e & mask)) begin
        nfail++;
        $display("FAIL %s: got fa/fb/sF/sD/sE/sM/sW/fD/fE/req/tmo=%b expected %b (mask %b)",
                 name, a, e, mask);
      end
    end
  endtask

  // One clock cycle: drive at falling edge, compare 2ns later, before the rising edge.
  task automatic cyc(input in_t v, input out_t e, input string name, input out_t mask);
    @(negedge clk);
    drive(v);
    sb.push_back(e);
    #2;
    check(name, mask);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  idle, acc, accr, br;
    out_t all, no_tmo;
    ntests = 0;
    nfail  = 0;
    all    = '1;
    no_tmo = '1;
    no_tmo.tmo = 1'b0;
    reset  = 1'b0;

    idle = mkin(0,0,0,0,0,0,0,0,0,2'b00,0,0,0);
    acc  = mkin(0,0,0,0,0,0,0,0,0,2'b00,0,1,0);
    accr = mkin(0,0,0,0,0,0,0,0,0,2'b00,0,1,1);

    //                 rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rsrc pcs macc rdy      fa fb sFD sBk fD fE req tmo
    vecs[0]  = '{mkin(0,0,5,0,0,5,5,1,1,2'b00,0,0,0), mk(2,0,0,0,0,0,0,0)};
    vecs[1]  = '{mkin(0,0,5,0,0,5,5,0,1,2'b00,0,0,0), mk(1,0,0,0,0,0,0,0)};
    vecs[2]  = '{mkin(0,0,5,0,0,0,0,1,1,2'b00,0,0,0), mk(0,0,0,0,0,0,0,0)};
    vecs[3]  = '{mkin(0,0,9,7,0,7,7,0,1,2'b00,0,0,0), mk(0,1,0,0,0,0,0,0)};
    vecs[4]  = '{mkin(0,0,4,4,0,4,6,1,1,2'b00,0,0,0), mk(2,2,0,0,0,0,0,0)};
    vecs[5]  = '{mkin(0,3,0,0,3,0,0,0,0,2'b01,0,0,0), mk(0,0,1,0,0,1,0,0)};
    vecs[6]  = '{mkin(0,0,0,0,0,0,0,0,0,2'b01,0,0,0), mk(0,0,0,0,0,0,0,0)};
    vecs[7]  = '{mkin(3,0,0,0,3,0,0,0,0,2'b00,0,0,0), mk(0,0,0,0,0,0,0,0)};
    vecs[8]  = '{mkin(8,0,0,0,8,0,0,0,0,2'b01,0,0,0), mk(0,0,1,0,0,1,0,0)};
    vecs[9]  = '{mkin(0,0,0,0,0,0,0,0,0,2'b00,1,0,0), mk(0,0,0,0,1,1,0,0)};
    vecs[10] = '{mkin(0,3,0,0,3,0,0,0,0,2'b01,1,0,0), mk(0,0,1,0,1,1,0,0)};
    vecs[11] = '{mkin(3,0,0,0,3,0,0,0,0,2'b10,0,0,0), mk(0,0,0,0,0,0,0,0)};

    // Reset forces controls even with an access and forwarding match present.
    cyc(mkin(0,0,5,0,0,5,0,1,0,2'b00,0,1,0), mk(0,0,0,0,1,1,0,0), "reset_forced", all);
    @(negedge clk);
    drive(idle);
    reset = 1'b1;

    for (int i = 0; i < 12; i++)
      cyc(vecs[i].i, vecs[i].o, $sformatf("vec%0d", i), all);

    // Zero-wait access stays in IDLE.
    cyc(accr, mk(0,0,0,0,0,0,1,0), "zero_wait", all);
    cyc(idle, mk(0,0,0,0,0,0,0,0), "zero_wait_idle", all);

    // Ready on the 4th cycle: 3 stalled cycles then release.
    for (int i = 1; i <= 3; i++)
      cyc(acc, mk(0,0,1,1,0,0,1,0), $sformatf("wait_stall%0d", i), all);
    cyc(accr, mk(0,0,0,0,0,0,1,0), "wait_release", all);
    cyc(idle, mk(0,0,0,0,0,0,0,0), "wait_back_idle", all);

    // Branch plus load-use held frozen under a memory stall, flushes fire on release.
    br = mkin(3,0,0,0,3,0,0,0,0,2'b01,1,1,0);
    for (int i = 1; i <= 3; i++)
      cyc(br, mk(0,0,1,1,0,0,1,0), $sformatf("br_stall%0d", i), all);
    br.rdy = 1'b1;
    cyc(br, mk(0,0,1,0,1,1,1,0), "br_release", all);
    cyc(idle, mk(0,0,0,0,0,0,0,0), "br_idle", all);

    // Watchdog: 16 stalled cycles, 17th released, then sticky flag.
    for (int i = 1; i <= 16; i++)
      cyc(acc, mk(0,0,1,1,0,0,1,0), $sformatf("tmo_stall%0d", i), all);
    cyc(acc, mk(0,0,0,0,0,0,1,0), "tmo_release", no_tmo);
    cyc(idle, mk(0,0,0,0,0,0,0,1), "tmo_flag", all);
    cyc(idle, mk(0,0,0,0,0,0,0,1), "tmo_sticky", all);
    cyc(accr, mk(0,0,0,0,0,0,1,1), "tmo_next_access", all);

    // New access up to cnt = 7, then asynchronous reset mid-cycle.
    for (int i = 0; i < 8; i++)
      cyc(acc, mk(0,0,1,1,0,0,1,1), $sformatf("pre_rst_stall%0d", i), all);
    @(negedge clk);
    drive(acc);
    sb.push_back(mk(0,0,1,1,0,0,1,1));
    #1;
    check("rst_cnt7_before", all);
    reset = 1'b0;
    sb.push_back(mk(0,0,0,0,1,1,0,0));
    #1;
    check("rst_async", all);
    @(negedge clk);
    drive(idle);
    reset = 1'b1;
    #2;
    sb.push_back(mk(0,0,0,0,0,0,0,0));
    check("rst_released", all);
    cyc(idle, mk(0,0,0,0,0,0,0,0), "rst_idle", all);
    cyc(acc,  mk(0,0,1,1,0,0,1,0), "rst_new_access", all);
    cyc(accr, mk(0,0,0,0,0,0,1,0), "rst_new_release", all);
    cyc(idle, mk(0,0,0,0,0,0,0,0), "rst_final_idle", all);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
